input_unit_ctrl_vc: RTL and testbench

INPUT_UNIT_CTRL_VC -- requirements
Module: input_unit_ctrl_vc

---
 rtl/input_unit_ctrl_vc.sv | 168 ++++++++++++++++
 tb/tb_input_unit_ctrl_vc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_unit_ctrl_vc.sv
// Input-unit control for a virtual-channel router port: per-VC IDLE/ROUTING/ACTIVE FSMs,
// round-robin RC and SA arbitration, switch-traversal staging. Optional IUC_PERF_CNT_EN adds stall_cnt.
module input_unit_ctrl_vc #(
    parameter int NUM_VC   = 2,
    parameter int DATA_W   = 36,
    parameter int DIR      = 5,
    parameter int INFO_LSB = 32,
    parameter int INFO_W   = 4,
    parameter int ADDR_LSB = 16,
    parameter int ADDR_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_VC-1:0]        in_data_valid,
    input  logic [NUM_VC-1:0]        fifo_empty,
    input  logic [NUM_VC-1:0]        fifo_empty_next,
    input  logic [NUM_VC*DATA_W-1:0] fifo_data,
    output logic [NUM_VC-1:0]        fifo_read_en,
    input  logic [DIR-1:0]           out_credit_avail,
    output logic [DIR-1:0]           out_credit_decre,
    output logic [NUM_VC-1:0]        in_credit,
    output logic                     rc_en,
    output logic [INFO_W-1:0]        route_info,
    output logic [ADDR_W-1:0]        route_addr,
    input  logic [DIR-1:0]           route_port,
    output logic                     sa_request,
    output logic [ADDR_W-1:0]        sa_addr,
    input  logic                     sa_grant,
    output logic [DATA_W-1:0]        st_data_in,
    output logic [DIR-1:0]           st_ctrl_in,
    output logic [NUM_VC-1:0]        st_vc_in
`ifdef IUC_PERF_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int PTR_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ROUTING, S_ACTIVE} vc_state_e;

    vc_state_e          r_state     [NUM_VC];
    vc_state_e          w_state_nxt [NUM_VC];
    logic [DIR-1:0]     r_route     [NUM_VC];
    logic [DATA_W-1:0]  w_head      [NUM_VC];
    logic [PTR_W-1:0]   r_rc_ptr, r_sa_ptr;
    logic [PTR_W-1:0]   w_rc_sel, w_sa_sel;
    logic               w_rc_vld, w_sa_vld, w_gnt;
    logic [NUM_VC-1:0]  w_elig, w_active, w_gnt_oh;

    // Index `off` positions after `ptr`, wrapping at NUM_VC (NUM_VC need not be a power of two).
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] ptr, input int off);
        int s;
        s = int'(ptr) + off;
        if (s >= NUM_VC) s = s - NUM_VC;
        return PTR_W'(s);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] sel);
        return (sel == PTR_W'(NUM_VC - 1)) ? '0 : PTR_W'(sel + 1'b1);
    endfunction

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign w_head[v]   = fifo_data[v*DATA_W +: DATA_W];
        assign w_active[v] = (r_state[v] == S_ACTIVE);
        // A VC may bid only when every output it routes to has a credit.
        assign w_elig[v]   = w_active[v] && ((out_credit_avail & r_route[v]) == r_route[v]);
        assign w_gnt_oh[v] = w_gnt && (w_sa_sel == PTR_W'(v));
    end

    always_comb begin
        w_rc_vld = 1'b0;
        w_rc_sel = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (!w_rc_vld && r_state[rr_idx(r_rc_ptr, i)] == S_ROUTING) begin
                w_rc_vld = 1'b1;
                w_rc_sel = rr_idx(r_rc_ptr, i);
            end
        end
    end

    always_comb begin
        w_sa_vld = 1'b0;
        w_sa_sel = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (!w_sa_vld && w_elig[rr_idx(r_sa_ptr, i)]) begin
                w_sa_vld = 1'b1;
                w_sa_sel = rr_idx(r_sa_ptr, i);
            end
        end
    end

    assign w_gnt = w_sa_vld && sa_grant;

    always_comb begin
        rc_en            = w_rc_vld;
        route_info       = w_rc_vld ? w_head[w_rc_sel][INFO_LSB +: INFO_W] : '0;
        route_addr       = w_rc_vld ? w_head[w_rc_sel][ADDR_LSB +: ADDR_W] : '0;
        sa_request       = w_sa_vld;
        sa_addr          = w_sa_vld ? w_head[w_sa_sel][ADDR_LSB +: ADDR_W] : '0;
        fifo_read_en     = w_gnt_oh;
        out_credit_decre = w_gnt ? r_route[w_sa_sel] : '0;
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            w_state_nxt[v] = r_state[v];
            case (r_state[v])
                S_IDLE:
                    if (in_data_valid[v] || !fifo_empty[v]) w_state_nxt[v] = S_ROUTING;
                S_ROUTING:
                    if (w_rc_vld && w_rc_sel == PTR_W'(v)) w_state_nxt[v] = S_ACTIVE;
                S_ACTIVE:
                    // After the pop, a non-empty buffer means a new head flit needs routing.
                    if (w_gnt_oh[v]) w_state_nxt[v] = fifo_empty_next[v] ? S_IDLE : S_ROUTING;
                default:
                    w_state_nxt[v] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_state[v] <= S_IDLE;
                r_route[v] <= '0;
            end
            r_rc_ptr <= '0;
            r_sa_ptr <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) r_state[v] <= w_state_nxt[v];
            if (w_rc_vld) begin
                r_route[w_rc_sel] <= route_port;
                r_rc_ptr          <= ptr_inc(w_rc_sel);
            end
            if (w_gnt) r_sa_ptr <= ptr_inc(w_sa_sel);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_credit  <= '0;
            st_vc_in   <= '0;
            st_ctrl_in <= '0;
            st_data_in <= '0;
        end else begin
            in_credit  <= w_gnt_oh;
            st_vc_in   <= w_gnt_oh;
            st_ctrl_in <= w_gnt ? r_route[w_sa_sel] : '0;
            st_data_in <= w_gnt ? w_head[w_sa_sel] : '0;
        end
    end

`ifdef IUC_PERF_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((|w_active) && !w_gnt && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_input_unit_ctrl_vc.sv
// Directed bench for input_unit_ctrl_vc with a per-cycle reference model and literal spot checks.
module tb_input_unit_ctrl_vc;
    localparam int NV = 2;
    localparam int DW = 36;
    localparam int D  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NV-1:0]   in_data_valid, fifo_empty, fifo_empty_next, fifo_read_en, in_credit, st_vc_in;
    logic [NV*DW-1:0] fifo_data;
    logic [D-1:0]    out_credit_avail, out_credit_decre, route_port, st_ctrl_in;
    logic            rc_en, sa_request, sa_grant;
    logic [3:0]      route_info;
    logic [15:0]     route_addr, sa_addr;
    logic [DW-1:0]   st_data_in;
`ifdef IUC_PERF_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    input_unit_ctrl_vc dut (
        .clk(clk), .rst(rst),
        .in_data_valid(in_data_valid), .fifo_empty(fifo_empty), .fifo_empty_next(fifo_empty_next),
        .fifo_data(fifo_data), .fifo_read_en(fifo_read_en),
        .out_credit_avail(out_credit_avail), .out_credit_decre(out_credit_decre), .in_credit(in_credit),
        .rc_en(rc_en), .route_info(route_info), .route_addr(route_addr), .route_port(route_port),
        .sa_request(sa_request), .sa_addr(sa_addr), .sa_grant(sa_grant),
        .st_data_in(st_data_in), .st_ctrl_in(st_ctrl_in), .st_vc_in(st_vc_in)
`ifdef IUC_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: 0 = waiting for a flit, 1 = needs a route, 2 = routed and bidding.
    int           m_st[NV], n_st[NV];
    logic [D-1:0] m_route[NV], n_route[NV];
    int           m_rcp, m_sap, n_rcp, n_sap, m_stall, n_stall;
    logic [NV-1:0] m_cred, n_cred;
    logic [D-1:0] m_stc, n_stc;
    logic [DW-1:0] m_std, n_std;

    localparam logic [DW-1:0] HEAD0 = {4'hA, 16'h1234, 16'h00C0};
    localparam logic [DW-1:0] HEAD1 = {4'h5, 16'hBEEF, 16'h00C1};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] hd(input int v);
        logic [NV*DW-1:0] f;
        f = fifo_data;
        return f[v*DW +: DW];
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin m_st[v] = 0; m_route[v] = '0; end
        m_rcp = 0; m_sap = 0; m_cred = '0; m_stc = '0; m_std = '0; m_stall = 0;
    endtask

    // Compare the DUT against the model mid-cycle and work out the model's next state.
    task automatic at_neg();
        int rc_w, sa_w, v;
        logic gnt, any_act;
        logic [NV-1:0] oh;
        logic [DW-1:0] h_rc, h_sa;
        @(negedge clk);
        rc_w = -1; sa_w = -1;
        for (int i = 0; i < NV; i++) begin
            v = (m_rcp + i) % NV;
            if (rc_w < 0 && m_st[v] == 1) rc_w = v;
        end
        for (int i = 0; i < NV; i++) begin
            v = (m_sap + i) % NV;
            if (sa_w < 0 && m_st[v] == 2 && ((out_credit_avail & m_route[v]) == m_route[v])) sa_w = v;
        end
        gnt  = (sa_w >= 0) && sa_grant;
        oh   = '0;
        h_rc = (rc_w >= 0) ? hd(rc_w) : '0;
        h_sa = (sa_w >= 0) ? hd(sa_w) : '0;
        if (gnt) oh[sa_w] = 1'b1;
        chk("m_rc_en", rc_en, rc_w >= 0);
        if (rc_w >= 0) begin
            chk("m_route_info", route_info, h_rc[35:32]);
            chk("m_route_addr", route_addr, h_rc[31:16]);
        end
        chk("m_sa_request", sa_request, sa_w >= 0);
        chk("m_sa_addr", sa_addr, h_sa[31:16]);
        chk("m_fifo_read_en", fifo_read_en, oh);
        chk("m_credit_decre", out_credit_decre, gnt ? m_route[sa_w] : '0);
        chk("m_in_credit", in_credit, m_cred);
        chk("m_st_vc_in", st_vc_in, m_cred);
        chk("m_st_ctrl_in", st_ctrl_in, m_stc);
        chk("m_st_data_in", st_data_in, m_std);
`ifdef IUC_PERF_CNT_EN
        chk("m_stall_cnt", stall_cnt, m_stall);
`endif
        any_act = 1'b0;
        for (int i = 0; i < NV; i++) begin
            n_st[i] = m_st[i]; n_route[i] = m_route[i];
            if (m_st[i] == 2) any_act = 1'b1;
            if (m_st[i] == 0 && (in_data_valid[i] || !fifo_empty[i])) n_st[i] = 1;
        end
        n_rcp = m_rcp; n_sap = m_sap;
        if (rc_w >= 0) begin
            n_st[rc_w] = 2; n_route[rc_w] = route_port; n_rcp = (rc_w + 1) % NV;
        end
        n_cred = oh; n_stc = '0; n_std = '0;
        if (gnt) begin
            n_st[sa_w] = fifo_empty_next[sa_w] ? 0 : 1;
            n_sap = (sa_w + 1) % NV;
            n_stc = m_route[sa_w];
            n_std = h_sa;
        end
        n_stall = (any_act && !gnt && m_stall < 65535) ? m_stall + 1 : m_stall;
    endtask

    task automatic to_pos();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            for (int v = 0; v < NV; v++) begin m_st[v] = n_st[v]; m_route[v] = n_route[v]; end
            m_rcp = n_rcp; m_sap = n_sap; m_cred = n_cred; m_stc = n_stc; m_std = n_std; m_stall = n_stall;
        end
        #1;
    endtask

    task automatic step();
        at_neg();
        to_pos();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_data_valid = '0; fifo_empty = '1; fifo_empty_next = '1;
        fifo_data = {HEAD1, HEAD0};
        out_credit_avail = 5'b11111; route_port = '0; sa_grant = 1'b0;
        model_reset();
        #1;
        chk("reset_rc_en", rc_en, 1'b0);
        chk("reset_sa_request", sa_request, 1'b0);
        chk("reset_in_credit", in_credit, 2'b00);
        chk("reset_st_vc_in", st_vc_in, 2'b00);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Single flit on VC0, full credit.
        route_port = 5'b00010; in_data_valid = 2'b01; fifo_empty = 2'b10; sa_grant = 1'b1;
        at_neg(); chk("a_c0_rc_en", rc_en, 1'b0); to_pos();
        in_data_valid = 2'b00;
        at_neg(); chk("a_c1_rc_en", rc_en, 1'b1); chk("a_c1_info", route_info, 4'hA);
        chk("a_c1_addr", route_addr, 16'h1234); to_pos();
        at_neg(); chk("a_c2_sa_req", sa_request, 1'b1); chk("a_c2_rd", fifo_read_en, 2'b01);
        chk("a_c2_decre", out_credit_decre, 5'b00010); to_pos();
        fifo_empty = 2'b11;
        at_neg(); chk("a_c3_credit", in_credit, 2'b01); chk("a_c3_ctrl", st_ctrl_in, 5'b00010);
        chk("a_c3_vc", st_vc_in, 2'b01); chk("a_c3_data", st_data_in, HEAD0); to_pos();
        at_neg(); chk("a_c4_credit", in_credit, 2'b00); to_pos();

        // Both VCs route together, then alternate grants with sa_grant held high.
        do_reset();
        sa_grant = 1'b0; route_port = 5'b01000; in_data_valid = 2'b11;
        fifo_empty = 2'b00; fifo_empty_next = 2'b00;
        step();
        in_data_valid = 2'b00;
        at_neg(); chk("b_c1_rc_addr", route_addr, 16'h1234); to_pos();
        route_port = 5'b00100;
        at_neg(); chk("b_c2_rc_addr", route_addr, 16'hBEEF); chk("b_c2_sa_addr", sa_addr, 16'h1234); to_pos();
        sa_grant = 1'b1;
        at_neg(); chk("b_c3_rd", fifo_read_en, 2'b01); chk("b_c3_decre", out_credit_decre, 5'b01000); to_pos();
        at_neg(); chk("b_c4_rd", fifo_read_en, 2'b10); chk("b_c4_vc", st_vc_in, 2'b01);
        chk("b_c4_rc_en", rc_en, 1'b1); to_pos();
        at_neg(); chk("b_c5_rd", fifo_read_en, 2'b01); chk("b_c5_vc", st_vc_in, 2'b10); to_pos();
        at_neg(); chk("b_c6_vc", st_vc_in, 2'b01); chk("b_c6_rd", fifo_read_en, 2'b10);
        // Reset lands in the middle of a granted cycle.
        rst = 1'b1;
        #1;
        chk("r_sa_req", sa_request, 1'b0); chk("r_rd", fifo_read_en, 2'b00);
        chk("r_rc_en", rc_en, 1'b0); chk("r_decre", out_credit_decre, 5'b0);
        chk("r_credit", in_credit, 2'b00); chk("r_vc", st_vc_in, 2'b00);
        chk("r_ctrl", st_ctrl_in, 5'b0); chk("r_data", st_data_in, 36'h0);
        model_reset();
        to_pos();
        rst = 1'b0; sa_grant = 1'b0; fifo_empty = 2'b11; fifo_empty_next = 2'b11;
        at_neg(); chk("r_no_credit", in_credit, 2'b00); to_pos();

        // Partial credit blocks the request until every routed output has one.
        route_port = 5'b00110; out_credit_avail = 5'b00100; in_data_valid = 2'b01;
        fifo_empty = 2'b10; sa_grant = 1'b1;
        at_neg(); chk("c_c0_rc_en", rc_en, 1'b0); to_pos();
        in_data_valid = 2'b00;
        at_neg(); chk("c_c1_rc_en", rc_en, 1'b1); to_pos();
        for (int i = 0; i < 10; i++) begin
            at_neg();
            chk("c_stall_req", sa_request, 1'b0);
            chk("c_stall_rd", fifo_read_en, 2'b00);
`ifdef IUC_PERF_CNT_EN
            if (i == 5) chk("c_stall_cnt5", stall_cnt, 16'd5);
`endif
            to_pos();
        end
        out_credit_avail = 5'b00110;
        at_neg(); chk("c_req", sa_request, 1'b1); chk("c_rd", fifo_read_en, 2'b01);
        chk("c_decre", out_credit_decre, 5'b00110); to_pos();
        fifo_empty = 2'b11;
        at_neg(); chk("c_credit", in_credit, 2'b01); chk("c_ctrl", st_ctrl_in, 5'b00110); to_pos();

`ifdef IUC_PERF_CNT_EN
        // Long stall drives the counter into saturation.
        sa_grant = 1'b0; route_port = 5'b00001; out_credit_avail = 5'b00000;
        in_data_valid = 2'b01; fifo_empty = 2'b10;
        step();
        in_data_valid = 2'b00;
        for (int i = 0; i < 65545; i++) step();
        at_neg(); chk("sat_stall_cnt", stall_cnt, 16'hFFFF); to_pos();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
